// File: rtl/oh_timer_ctrl.sv
// oh_timer_ctrl: IDLE/LOAD/RUN sequencer for an external down-counting interval timer.
// Optional tick prescaler is built only when OH_TIMER_PRESCALE_EN is defined.
module oh_timer_ctrl #(
  parameter int N  = 32,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [N-1:0]  period,
  input  logic [PW-1:0] prescale,
  input  logic          irq_clear,
  output logic          cnt_load,
  output logic [N-1:0]  cnt_load_data,
  output logic          cnt_en,
  output logic          cnt_dec,
  output logic          cnt_autowrap,
  input  logic [N-1:0]  cnt_count,
  output logic          busy,
  output logic          expire,
  output logic          irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_expire;
  logic   r_irq;
  logic   w_tick;
  logic   w_term;
  logic   w_expire_set;

`ifdef OH_TIMER_PRESCALE_EN
  logic [PW-1:0] r_pcnt;
  // >= keeps pcnt bounded even if prescale is lowered mid-run
  assign w_tick = (r_state == S_RUN) && (r_pcnt >= prescale);
`else
  logic w_unused_prescale;
  assign w_unused_prescale = ^prescale;
  assign w_tick = (r_state == S_RUN);
`endif

  assign w_term       = w_tick && (cnt_count == '0);
  assign w_expire_set = w_term && !stop && !start;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= S_IDLE;
      r_expire <= 1'b0;
      r_irq    <= 1'b0;
`ifdef OH_TIMER_PRESCALE_EN
      r_pcnt   <= '0;
`endif
    end else begin
      r_expire <= w_expire_set;
      // an irq_clear coinciding with a visible expire pulse loses to the set
      r_irq    <= w_expire_set | r_expire | (r_irq & ~irq_clear);
`ifdef OH_TIMER_PRESCALE_EN
      if ((r_state != S_RUN) || w_tick) r_pcnt <= '0;
      else                              r_pcnt <= r_pcnt + PW'(1);
`endif
      if (stop) begin
        r_state <= S_IDLE;
      end else if (start) begin
        r_state <= S_LOAD;
      end else begin
        unique case (r_state)
          S_IDLE:  r_state <= S_IDLE;
          S_LOAD:  r_state <= S_RUN;
          S_RUN:   if (w_term && !periodic) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cnt_load      = !stop && ((r_state == S_LOAD) || (w_term && periodic && !start));
  assign cnt_en        = !stop && w_tick && !(w_term && periodic);
  assign cnt_load_data = period;
  assign cnt_dec       = 1'b1;
  assign cnt_autowrap  = 1'b0;
  assign busy          = (r_state != S_IDLE);
  assign expire        = r_expire;
  assign irq           = r_irq;

endmodule
